// File: rtl/fmul_issue.sv
// fmul_issue: pipelined issue/retire wrapper around the combinational fmul multiplier.
// Optional sticky overflow flag is enabled by defining FMUL_OVF_STICKY_EN.
module fmul (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  logic s, z1, z2, i1, i2, nan, hi, rnd;
  logic [47:0] p;
  logic [23:0] m;
  logic [24:0] mr;
  logic [9:0] eu;
  // Denormals flush to zero; round to nearest even; eu keeps the exponent biased by 2*127
  always_comb begin
    s = x1[31] ^ x2[31];
    z1 = x1[30:23] == 8'h00;
    z2 = x2[30:23] == 8'h00;
    i1 = x1[30:23] == 8'hFF;
    i2 = x2[30:23] == 8'hFF;
    nan = (i1 & |x1[22:0]) | (i2 & |x2[22:0]) | (i1 & z2) | (i2 & z1);
    p = {24'h0, 1'b1, x1[22:0]} * {24'h0, 1'b1, x2[22:0]};
    hi = p[47];
    m = hi ? p[47:24] : p[46:23];
    rnd = hi ? p[23] & (|p[22:0] | m[0]) : p[22] & (|p[21:0] | m[0]);
    mr = {1'b0, m} + 25'(rnd);
    eu = {2'b0, x1[30:23]} + {2'b0, x2[30:23]} + 10'(hi) + 10'(mr[24]);
    ovf = !(nan | i1 | i2 | z1 | z2) && eu >= 10'd382;
    y = nan ? 32'h7FC00000 :
        (i1 | i2) ? {s, 8'hFF, 23'h0} :
        (z1 | z2 || eu <= 10'd127) ? {s, 31'h0} :
        ovf ? {s, 8'hFF, 23'h0} :
        {s, 8'(eu - 10'd127), mr[24] ? mr[23:1] : mr[22:0]};
  end
endmodule

module fmul_issue #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 33 + TAG_W;
  logic [31:0] s1_x1, s1_x2, y;
  logic [TAG_W-1:0] s1_tag;
  logic s1_v, ovf, acc, pop;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  fmul u_fmul (.x1(s1_x1), .x2(s1_x2), .y(y), .ovf(ovf));
  // Credit counts the S1 entry as already occupying a FIFO slot, so push never needs a full check
  assign in_ready = ({1'b0, count} + (CW+1)'(s1_v)) < (CW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign busy = s1_v | out_valid;
  assign head = mem[rptr];
  assign {out_y, out_ovf, out_tag} = out_valid ? head : '0;
  always_ff @(posedge clk) begin
    if (acc) begin
      s1_x1 <= in_x1;
      s1_x2 <= in_x2;
      s1_tag <= in_tag;
    end
    if (s1_v) mem[wptr] <= {y, ovf, s1_tag};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      s1_v <= 1'b0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      s1_v <= acc;
      wptr <= wptr + AW'(s1_v);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(s1_v) - CW'(pop);
    end
  end
`ifdef FMUL_OVF_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (pop & out_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
`else
  logic unused;
  assign unused = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue: table vectors, directed corner sequences and a randomized run
// checked by a queue-based reference model of fmul_issue.
module tb_fmul_issue;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
`ifdef FMUL_OVF_STICKY_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic out_ovf, busy, ovf_clr = 0, ovf_sticky;
  logic [31:0] in_x1 = 0, in_x2 = 0, out_y;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  int tests = 0, fails = 0, cyc = 0;

  fmul_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1),
    .in_x2(in_x2), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag),
    .busy(busy), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endfunction

  // IEEE single multiply from first principles: integer significand product, nearest-even, FTZ
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, sh, e;
    bit az, bz, ai, bi;
    longint m, q, r, half;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = ea == 0; bz = eb == 0; ai = ea == 255; bi = eb == 255;
    if ((ai && a[22:0] != 0) || (bi && b[22:0] != 0) || (ai && bz) || (bi && az)) return {1'b0, 32'h7FC00000};
    if (ai || bi) return {1'b0, s, 8'hFF, 23'h0};
    if (az || bz) return {1'b0, s, 31'h0};
    m = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh = m >= (longint'(1) << 47) ? 24 : 23;
    q = m >> sh;
    r = m - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q[0])) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      sh++;
    end
    e = ea + eb - 150 + sh;
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 19);
    v = $urandom;
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) v[30:23] = 8'($urandom_range(1, 60));
    else if (k < 7) v[30:23] = 8'($urandom_range(190, 254));
    else v[30:23] = 8'($urandom_range(64, 190));
    return v;
  endfunction

  // Reference model: outstanding requests in acceptance order, each stamped with its accept cycle
  typedef struct { logic [32:0] r; logic [TAG_W-1:0] tag; int cyc; } ex_t;
  ex_t q[$];
  ex_t e;
  logic sm = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      sm = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sticky", ovf_sticky, 0);
    end else begin
      chk("mon_in_ready", in_ready, q.size() < DEPTH);
      chk("mon_out_valid", out_valid, q.size() > 0 && q[0].cyc <= cyc - 2);
      chk("mon_sticky", ovf_sticky, sm & SE);
      if (!out_valid) chk("mon_gate", {out_y, out_ovf, out_tag}, 0);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("mon_y", out_y, e.r[31:0]);
        chk("mon_ovf", out_ovf, e.r[32]);
        chk("mon_tag", out_tag, e.tag);
        if (e.r[32]) sm = 1;
        else if (ovf_clr) sm = 0;
      end else if (ovf_clr) sm = 0;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_mul(in_x1, in_x2), in_tag, cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [31:0] x1, x2, y; logic ovf; } vec_t;
  vec_t vt[12];
  int nt;
  int got[$];

  initial begin
    vt = '{
      '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0},
      '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1},
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0},
      '{32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0},
      '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0},
      '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0},
      '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0},
      '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0},
      '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0}
    };
    repeat (2) step();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outs", {out_valid, out_y, out_ovf, out_tag, busy, ovf_sticky}, 0);
    rst = 0;
    step();
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_outs", {out_valid, busy, ovf_sticky}, 0);

    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_x1 = vt[i].x1; in_x2 = vt[i].x2; in_tag = TAG_W'(i);
      step();
      in_valid = 0;
      chk($sformatf("vec%0d_lat1", i), out_valid, 0);
      chk($sformatf("vec%0d_busy1", i), busy, 1);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_y", i), out_y, vt[i].y);
      chk($sformatf("vec%0d_ovf", i), out_ovf, vt[i].ovf);
      chk($sformatf("vec%0d_tag", i), out_tag, TAG_W'(i));
      step();
      chk($sformatf("vec%0d_busy_drop", i), busy, 0);
    end

    // Sticky: pop of an overflow sets; clear coinciding with an overflow pop loses; lone clear wins
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("sticky_clr0", ovf_sticky, 0);
    in_valid = 1; in_x1 = 32'h7F000000; in_x2 = 32'h7F000000; in_tag = 1;
    step(); in_valid = 0; step(); step();
    chk("sticky_set", ovf_sticky, SE);
    out_ready = 0; in_valid = 1;
    step(); in_valid = 0; step();
    out_ready = 1; ovf_clr = 1;
    step(); ovf_clr = 0;
    chk("sticky_set_wins", ovf_sticky, SE);
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("sticky_clear", ovf_sticky, 0);

    // Backpressure: tags 0..5 offered, only DEPTH taken while the consumer stalls
    out_ready = 0; nt = 0; in_x1 = 32'h3F800000; in_x2 = 32'h40000000;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1; in_tag = TAG_W'(nt);
      if (in_ready) nt++;
      step();
    end
    chk("bp_accepted", nt, DEPTH);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) got.push_back(int'(out_tag));
      in_valid = nt < 6; in_tag = TAG_W'(nt);
      if (c == 1) chk("bp_ready_rise", in_ready, 1);
      if (in_valid && in_ready) nt++;
      step();
    end
    in_valid = 0;
    chk("bp_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) chk($sformatf("bp_order%0d", k), got[k], k);

    // Streaming: 8 back-to-back requests retire on 8 consecutive cycles
    for (int i = 0; i < 11; i++) begin
      in_valid = i < 8; in_tag = TAG_W'(i); in_x1 = 32'h40000000; in_x2 = 32'h3F800000 + i;
      if (i < 8) chk($sformatf("stream_in_ready%0d", i), in_ready, 1);
      if (i >= 2 && i < 10) begin
        chk($sformatf("stream_valid%0d", i), out_valid, 1);
        chk($sformatf("stream_tag%0d", i), out_tag, TAG_W'(i - 2));
      end
      if (i == 10) chk("stream_end", out_valid, 0);
      step();
    end

    // Flush with S1 occupied, two queued results and a concurrent input request
    out_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; in_tag = TAG_W'(i);
      step();
    end
    chk("flush_pre_valid", out_valid, 1);
    in_valid = 1; in_tag = 9; flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_stale%0d", i), out_valid, 0);
      step();
    end

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_tag = TAG_W'(i + 20); in_x1 = rnd_op(); in_x2 = rnd_op();
      step();
    end
    in_valid = 0; rst = 1;
    #1;
    chk("midrst_outs", {out_valid, out_y, out_ovf, out_tag, busy, ovf_sticky}, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    rst = 0;
    step(); step();
    chk("midrst_no_result", out_valid, 0);
    in_valid = 1; in_x1 = 32'h40000000; in_x2 = 32'h40400000; in_tag = 7;
    step(); in_valid = 0; step();
    chk("midrst_y", out_y, 32'h40C00000);
    chk("midrst_tag", out_tag, 7);
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_x1 = rnd_op(); in_x2 = rnd_op(); in_tag = TAG_W'($urandom);
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 59) == 0;
      ovf_clr = $urandom_range(0, 19) == 0;
      step();
    end
    flush = 0; in_valid = 0; ovf_clr = 0; out_ready = 1;
    repeat (DEPTH + 3) step();
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
